// File: rtl/pmem_line_responder.sv
// Bridges 256-bit cache line requests onto a 4-beat, 64-bit burst memory port.
// Reads assemble a line beat by beat; write-backs stream a latched line out beat by beat.
module pmem_line_responder (
  input  logic         clk,
  input  logic         rst,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [31:0]  pmem_address,
  input  logic [255:0] pmem_wdata,
  output logic         pmem_resp,
  output logic [255:0] pmem_rdata,
  output logic         burst_read,
  output logic         burst_write,
  output logic [31:0]  burst_address,
  output logic [63:0]  burst_wdata,
  input  logic [63:0]  burst_rdata,
  input  logic         burst_resp,
  output logic [1:0]   fsm_state
);

  // Handshake: the cache holds pmem_read/pmem_write until a one-cycle pmem_resp and
  // drops it the cycle after. burst_read/burst_write stay high until the 4th burst_resp;
  // each burst_resp cycle moves exactly one beat, and burst_resp outside a burst is ignored.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state, next_state;
  logic [1:0]     k;
  logic [31:0]    addr_q;
  logic [255:0]   wline_q;
  logic [255:0]   rline_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (pmem_write)     next_state = WRITE;
        else if (pmem_read) next_state = READ;
      end
      READ:    if (burst_resp && k == 2'd3) next_state = DONE;
      WRITE:   if (burst_resp && k == 2'd3) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The read line is only ever written by read beats, so it survives write-backs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k       <= 2'd0;
      addr_q  <= 32'h0;
      wline_q <= 256'h0;
      rline_q <= 256'h0;
    end else begin
      case (state)
        IDLE: begin
          if (pmem_write) begin
            addr_q  <= pmem_address & 32'hFFFF_FFE0;
            wline_q <= pmem_wdata;
            k       <= 2'd0;
          end else if (pmem_read) begin
            addr_q <= pmem_address & 32'hFFFF_FFE0;
            k      <= 2'd0;
          end
        end
        READ: begin
          if (burst_resp) begin
            rline_q[{k, 6'b0} +: 64] <= burst_rdata;
            k <= k + 2'd1;
          end
        end
        WRITE: begin
          if (burst_resp) k <= k + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    burst_read    = (state == READ);
    burst_write   = (state == WRITE);
    pmem_resp     = (state == DONE);
    burst_address = (state == READ || state == WRITE) ? addr_q : 32'h0;
    burst_wdata   = (state == WRITE) ? wline_q[{k, 6'b0} +: 64] : 64'h0;
    pmem_rdata    = rline_q;
    fsm_state     = state;
  end

endmodule

// File: tb/tb_pmem_line_responder.sv
// Self-checking bench for pmem_line_responder: bench acts as cache and burst memory,
// with expected lines and write beats queued at issue and checked on DUT output.
module tb_pmem_line_responder;

  logic         clk;
  logic         rst;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic         pmem_resp;
  logic [255:0] pmem_rdata;
  logic         burst_read;
  logic         burst_write;
  logic [31:0]  burst_address;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata;
  logic         burst_resp;
  logic [1:0]   fsm_state;

  pmem_line_responder dut (
    .clk          (clk),
    .rst          (rst),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_resp    (pmem_resp),
    .pmem_rdata   (pmem_rdata),
    .burst_read   (burst_read),
    .burst_write  (burst_write),
    .burst_address(burst_address),
    .burst_wdata  (burst_wdata),
    .burst_rdata  (burst_rdata),
    .burst_resp   (burst_resp),
    .fsm_state    (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [255:0] exp_q[$];
  logic [63:0]  wb_q[$];
  logic [255:0] last_line;
  int total;
  int bad;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_resp"},  pmem_resp, 0);
    check_val({tag, "_bread"}, burst_read, 0);
    check_val({tag, "_bwrite"}, burst_write, 0);
    check_val({tag, "_baddr"}, burst_address, 0);
    check_val({tag, "_bwdata"}, burst_wdata, 0);
    check_val({tag, "_state"}, fsm_state, 0);
  endtask

  // Drive one request (or a simultaneous read+write) and act as burst memory until done.
  // period: burst_resp every period-th burst cycle; 0 means random stalls.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [255:0] line, input logic [63:0] seed,
                         input int period, output int lat);
    logic        rd_pend, wr_pend, resp;
    logic [31:0] exp_addr;
    logic [255:0] exp;
    int n, tick, rbeat;
    rd_pend = rd; wr_pend = wr;
    n = 0; tick = 0; rbeat = 0; lat = -1;
    exp_addr = {addr[31:5], 5'b0};
    if (wr) begin
      exp_q.push_back(last_line);
      for (int b = 0; b < 4; b++) wb_q.push_back(line[64*b +: 64]);
    end
    if (rd) exp_q.push_back({seed + 64'd3, seed + 64'd2, seed + 64'd1, seed});
    burst_resp   = 1'b0;
    pmem_address = addr;
    pmem_wdata   = line;
    pmem_read    = rd;
    pmem_write   = wr;
    while ((rd_pend || wr_pend) && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 1 && !(rd && wr)) begin
        pmem_address = $urandom;
        pmem_wdata   = {8{$urandom}};
      end
      burst_resp = 1'b0;
      check_val("rw_excl", burst_read & burst_write, 0);
      if (burst_read || burst_write) begin
        check_val("baddr", burst_address, exp_addr);
        resp = (period == 0) ? 1'($urandom_range(0, 1)) : ((tick % period) == period - 1);
        tick++;
        if (burst_read) begin
          burst_rdata = seed + 64'(rbeat);
          if (resp) rbeat++;
        end
        if (burst_write) begin
          check_val("rd_hold", pmem_rdata, last_line);
          if (wb_q.size() > 0) begin
            check_val("wbeat", burst_wdata, wb_q[0]);
            if (resp) void'(wb_q.pop_front());
          end
        end
        burst_resp = resp;
      end
      if (pmem_resp) begin
        if (lat < 0) lat = n;
        if (exp_q.size() > 0) begin
          exp = exp_q.pop_front();
          check_val("rdata", pmem_rdata, exp);
          last_line = exp;
        end else begin
          check_val("extra_resp", 1, 0);
        end
        if (wr_pend) begin
          wr_pend = 1'b0; pmem_write = 1'b0;
        end else begin
          rd_pend = 1'b0; pmem_read = 1'b0;
        end
        burst_resp = 1'b1;  // stray ack while in DONE must be ignored
      end
    end
    if (rd_pend || wr_pend) check_val("timeout", 1, 0);
    pmem_read = 1'b0; pmem_write = 1'b0;
    @(negedge clk);
    check_val("resp_pulse", pmem_resp, 0);
    burst_resp = 1'b0;
    check_val("wb_left", wb_q.size(), 0);
    exp_q.delete();
    wb_q.delete();
  endtask

  initial begin
    int lat;
    logic [63:0] seed;
    total = 0; bad = 0;
    last_line = 256'h0;
    rst = 1'b1;
    pmem_read = 1'b0; pmem_write = 1'b0;
    pmem_address = 32'h0; pmem_wdata = 256'h0;
    burst_rdata = 64'h0; burst_resp = 1'b0;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    check_val("reset_rdata", pmem_rdata, 0);
    rst = 1'b0;
    @(negedge clk);

    // read, resp tied high: latency and assembled line
    run_txn(1'b1, 1'b0, 32'h0000_1234, 256'h0, 64'hA0, 1, lat);
    check_val("read_latency", lat, 5);
    check_val("read_line", pmem_rdata, {64'hA3, 64'hA2, 64'hA1, 64'hA0});

    // write with stalls; read line must survive
    run_txn(1'b0, 1'b1, 32'h0000_8040, {64'hD3, 64'hD2, 64'hD1, 64'hD0}, 64'h0, 3, lat);
    check_val("write_latency", lat, 13);
    check_val("after_write", pmem_rdata, {64'hA3, 64'hA2, 64'hA1, 64'hA0});

    // simultaneous read+write: write first, then read
    run_txn(1'b1, 1'b1, 32'hCAFE_0017, {64'h13, 64'h12, 64'h11, 64'h10}, 64'hB000, 1, lat);
    check_val("both_line", pmem_rdata, {64'hB003, 64'hB002, 64'hB001, 64'hB000});

    // burst_resp in IDLE is ignored
    for (int i = 0; i < 4; i++) begin
      burst_resp = 1'b1;
      @(negedge clk);
      check_quiet("idle_ack");
    end
    burst_resp = 1'b0;

    // reset after the 2nd read beat
    pmem_address = 32'h0000_2000; pmem_read = 1'b1;
    @(negedge clk);
    burst_resp = 1'b1; burst_rdata = 64'hEE0;
    @(negedge clk);
    burst_rdata = 64'hEE1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_quiet("midrst");
    check_val("midrst_rdata", pmem_rdata, 0);
    pmem_read = 1'b0; burst_resp = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    last_line = 256'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("post_rst_resp", pmem_resp, 0);
    end
    run_txn(1'b1, 1'b0, 32'h0000_2008, 256'h0, 64'hC0, 1, lat);
    check_val("post_rst_line", pmem_rdata, {64'hC3, 64'hC2, 64'hC1, 64'hC0});

    // random mix with random stalls
    for (int i = 0; i < 8; i++) begin
      seed = {$urandom, $urandom};
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
              {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
              seed, 0, lat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pmem_line_responder.md
PMEM_LINE_RESPONDER -- requirements
Module: pmem_line_responder

Interface
REQ-001 The block SHALL have no parameters; line width is fixed at 256 bits and burst beat width at 64 bits, giving 4 beats per line.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 pmem_read  input  1  line read request from the cache; held until pmem_resp.
REQ-005 pmem_write  input  1  line write-back request from the cache; held until pmem_resp.
REQ-006 pmem_address  input  32  line address; bits [4:0] are ignored.
REQ-007 pmem_wdata  input  256  write-back line.
REQ-008 pmem_resp  output  1  one-cycle completion pulse.
REQ-009 pmem_rdata  output  256  assembled read line.
REQ-010 burst_read  output  1  burst read request to memory; held until the 4th burst_resp.
REQ-011 burst_write  output  1  burst write request to memory; held until the 4th burst_resp.
REQ-012 burst_address  output  32  line-aligned address {addr[31:5], 5'b0}.
REQ-013 burst_wdata  output  64  current write beat.
REQ-014 burst_rdata  input  64  read beat; valid when burst_resp=1.
REQ-015 burst_resp  input  1  per-beat acknowledge; may be stalled for any number of cycles between beats.

Function
REQ-016 The FSM SHALL have four states: IDLE, READ, WRITE, DONE.
REQ-017 In IDLE with pmem_write=1, the block SHALL latch the aligned address and pmem_wdata, clear the beat counter and go to WRITE.
REQ-018 In IDLE with pmem_read=1 and pmem_write=0, the block SHALL latch the aligned address, clear the beat counter and go to READ.
REQ-019 If pmem_read and pmem_write are both 1 in IDLE, the write SHALL win; the read is serviced from IDLE afterwards if still asserted.
REQ-020 In READ, burst_read SHALL be 1.
REQ-021 Each burst_resp cycle in READ SHALL store burst_rdata into line bits [64*k+63:64*k], where k is the 2-bit beat counter, then increment k.
REQ-022 On the burst_resp with k=3, READ SHALL go to DONE.
REQ-023 In WRITE, burst_write SHALL be 1 and burst_wdata SHALL equal latched line bits [64*k+63:64*k].
REQ-024 Each burst_resp cycle in WRITE SHALL increment k; on k=3 WRITE SHALL go to DONE.
REQ-025 In DONE, pmem_resp SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE unconditionally.
REQ-026 pmem_resp SHALL be 0 in every other state.
REQ-027 pmem_rdata SHALL be driven from the read line register and SHALL hold its value until the next read's first beat overwrites beat 0.
REQ-028 A write SHALL NOT modify pmem_rdata.
REQ-029 burst_address SHALL be the latched address, stable for the whole transaction.
REQ-030 burst_read and burst_write SHALL never be 1 together.
REQ-031 burst_address and burst_wdata SHALL be 0 in IDLE and DONE.
REQ-032 Minimum latency with burst_resp tied high: request seen in IDLE at cycle 0; beats at cycles 1-4; pmem_resp at cycle 5.
REQ-033 burst_resp seen in IDLE or DONE SHALL be ignored.
REQ-034 Changes to pmem_address or pmem_wdata after acceptance SHALL be ignored.
REQ-035 The requester drops its request in the cycle after pmem_resp; the IDLE entered after DONE therefore sees no stale request.

Reset
REQ-036 On rst=1 the state SHALL become IDLE immediately (asynchronously), with k=0, the latched address and write line cleared to 0, and pmem_rdata = 256'h0.
REQ-037 While reset is active, pmem_resp, burst_read, burst_write, burst_address and burst_wdata SHALL all be 0.
REQ-038 A reset in mid-burst SHALL abandon the transaction; no pmem_resp SHALL follow it.

Verification
REQ-039 Read, burst_resp tied high, burst_rdata = 64'hA0..A3 per beat, address 32'h0000_1234 -> burst_address = 32'h0000_1220; pmem_resp at cycle 5; pmem_rdata = {A3,A2,A1,A0}.
REQ-040 Write of line {D3,D2,D1,D0}, burst_resp high only every 3rd cycle -> burst_wdata steps D0, D1, D2, D3; burst_write is held throughout; one pmem_resp pulse.
REQ-041 pmem_read=pmem_write=1 -> write burst first, then read burst; two pmem_resp pulses, write first.
REQ-042 rst pulsed after the 2nd read beat -> all outputs 0 at once; no pmem_resp; the next read completes normally with the correct line.
REQ-043 Write following a read -> pmem_rdata keeps the previous read line throughout the write.
REQ-044 burst_resp pulsed while in IDLE -> no state change and no pmem_resp.
